// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit-side arbiter.
package uart_pkg;

  localparam int FRAME_CYCLES = 10;
  localparam int CNT_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request above last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter, pacing loads one frame period apart.
//   state | meaning
//   IDLE  | no frame in flight, grant window open
//   SEND  | one-cycle load pulse to the transmitter
//   WAIT  | pacing countdown P-1..1; grant window open at 1
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = uart_pkg::FRAME_CYCLES,
  parameter int GAP_CYCLES   = 0,
  localparam int LG_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_byte_ready,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [LG_W-1:0]      last_grant
);

  localparam int PERIOD = FRAME_CYCLES + GAP_CYCLES;

  arb_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [LG_W-1:0]    grant_idx;
  logic               any_grant;
  logic               window;
  logic               handshake;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    window    = 1'b0;
    case (state)
      ST_IDLE: window = 1'b1;
      ST_SEND: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = CNT_W'(PERIOD - 1);
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          window    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    handshake = window && any_grant && !reset;
    if (handshake) state_nxt = ST_SEND;
  end

  assign req_ready = handshake ? grant : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      tx_byte_ready <= 1'b0;
      tx_data       <= 8'h00;
      last_grant    <= LG_W'(NUM_REQ - 1);
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      tx_byte_ready <= handshake;
      if (handshake) begin
        tx_data    <= req_data[int'(grant_idx)*8 +: 8];
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: two instances (no gap, 3-cycle gap) against a timing-rule model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N    = 4;
  localparam int NI   = 2;
  localparam int GAP0 = 0;
  localparam int GAP1 = 3;

  logic             clk;
  logic             reset;
  logic [N-1:0]     rv [NI];
  logic [8*N-1:0]   rd [NI];
  logic [N-1:0]     rr [NI];
  logic             tbr [NI];
  logic [7:0]       txd_data [NI];
  logic             bsy [NI];
  logic [1:0]       lg [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
    .tx_byte_ready(tbr[0]), .tx_data(txd_data[0]), .busy(bsy[0]), .last_grant(lg[0]));

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
    .tx_byte_ready(tbr[1]), .tx_data(txd_data[1]), .busy(bsy[1]), .last_grant(lg[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int period [NI] = '{FRAME_CYCLES + GAP0, FRAME_CYCLES + GAP1};
  int gap    [NI] = '{GAP0, GAP1};

  // model: a load is accepted at most once per period, measured from the last handshake
  bit         have_hs [NI];
  int         last_hs [NI];
  int         ptr [NI];
  logic [7:0] exp_data [NI];
  int         hs_win [NI];
  int         last_pulse [NI];
  int         bits_left [NI];
  logic [9:0] shift [NI];
  int         ones_run [NI];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input int i);
    if (reset) return -1;
    if (have_hs[i] && (cyc - last_hs[i]) < period[i]) return -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr[i] + k) % N;
      if (rv[i][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      have_hs[i]    = 1'b0;
      last_hs[i]    = 0;
      ptr[i]        = N - 1;
      exp_data[i]   = 8'h00;
      last_pulse[i] = -1;
      bits_left[i]  = 0;
      shift[i]      = '1;
      ones_run[i]   = 0;
    end
  endtask

  task automatic step(input bit chk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int w;
      int d;
      logic [N-1:0] er;
      w = pick(i);
      hs_win[i] = w;
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      d = cyc - last_hs[i];
      if (chk) begin
        check_val($sformatf("req_ready[%0d]", i), 32'(rr[i]), 32'(er));
        check_val($sformatf("tx_byte_ready[%0d]", i), 32'(tbr[i]), 32'(have_hs[i] && d == 1));
        check_val($sformatf("tx_data[%0d]", i), 32'(txd_data[i]), 32'(exp_data[i]));
        check_val($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(have_hs[i] && d >= 1 && d <= period[i]));
        check_val($sformatf("last_grant[%0d]", i), 32'(lg[i]), 32'(ptr[i]));
        if (bits_left[i] > 0) begin
          shift[i] = shift[i] >> 1;
          bits_left[i]--;
          if (bits_left[i] == 0) ones_run[i] = 1;
        end else begin
          ones_run[i]++;
        end
        if (tbr[i] === 1'b1) begin
          check_val($sformatf("truncation[%0d]", i), 32'(bits_left[i]), 32'd0);
          if (last_pulse[i] >= 0) begin
            check_val($sformatf("spacing_ok[%0d]", i), 32'(cyc - last_pulse[i] >= period[i]), 32'd1);
            if (cyc - last_pulse[i] == period[i])
              check_val($sformatf("idle_ones[%0d]", i), 32'(ones_run[i]), 32'(1 + gap[i]));
          end
          shift[i]      = {1'b1, txd_data[i], 1'b0};
          bits_left[i]  = FRAME_CYCLES;
          last_pulse[i] = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (hs_win[i] >= 0) begin
          have_hs[i]  = 1'b1;
          last_hs[i]  = cyc;
          ptr[i]      = hs_win[i];
          exp_data[i] = rd[i][8*hs_win[i] +: 8];
        end
      end
    end
    cyc++;
  endtask

  task automatic rand_stim();
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < N; r++) begin
        if (rv[i][r] && hs_win[i] == r) begin
          rv[i][r] = ($urandom_range(0, 1) == 1);
          rd[i][8*r +: 8] = 8'($urandom);
        end else if (rv[i][r]) begin
          if ($urandom_range(0, 15) == 0) rv[i][r] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rv[i][r] = 1'b1;
          rd[i][8*r +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      step(1'b1);
      if (rnd) rand_stim();
    end
  endtask

  task automatic set_all(input logic [N-1:0] v, input logic [8*N-1:0] dat);
    for (int i = 0; i < NI; i++) begin
      rv[i] = v;
      rd[i] = dat;
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    set_all(4'b1111, 32'hDEAD_BEEF);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    set_all(4'b0000, 32'h0);
    run(2, 1'b0);

    // single requester 2 with A5, offered for one cycle only
    set_all(4'b0100, 32'h00A5_0000);
    run(1, 1'b0);
    set_all(4'b0000, 32'h00A5_0000);
    run(14, 1'b0);

    // all four continuously valid, fresh pointer
    reset = 1'b1;
    run(1, 1'b0);
    reset = 1'b0;
    set_all(4'b1111, 32'h4433_2211);
    run(60, 1'b0);

    // fairness between 0 and 3 starting from last_grant=0
    set_all(4'b0000, 32'h4433_2211);
    run(16, 1'b0);
    set_all(4'b0001, 32'h4433_2211);
    run(1, 1'b0);
    set_all(4'b1001, 32'h4433_2211);
    run(60, 1'b0);

    set_all(4'b0000, 32'h0);
    run(16, 1'b0);
    run(500, 1'b1);

    // reset while instance 0 is in WAIT with counter 5, request pending
    set_all(4'b0000, 32'h0);
    run(16, 1'b0);
    rv[0] = 4'b1111;
    rd[0] = 32'h5A6B_7C8D;
    run(6, 1'b0);
    reset = 1'b1;
    run(1, 1'b0);
    reset = 1'b0;
    run(20, 1'b0);

    run(200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (10-bit frame: start, 8 data, stop; one bit per clk) between NUM_REQ byte sources.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the transmitter's byte_ready/data load interface and paces loads so a frame is never truncated.
- Sits between the system-side byte producers and the transmitter inside the UART top level.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
FRAME_CYCLES, 10, clk cycles per frame (1 start + 8 data + 1 stop)
GAP_CYCLES, 0, extra idle-line (TXD=1) cycles inserted between frames (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge of clk
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  flat bus; requester i on bits [8i+7:8i]
req_ready  output  NUM_REQ  one-hot accept strobe (combinational), gated by req_valid
tx_byte_ready  output  1  one-cycle load pulse to transmitter byte_ready (registered)
tx_data  output  8  byte to transmitter data (registered)
busy  output  1  high whenever state != IDLE
last_grant  output  $clog2(NUM_REQ)  index of most recently accepted requester

Behaviour:
- Reset values: state=IDLE, tx_byte_ready=0, tx_data=8'h00, busy=0, last_grant=NUM_REQ-1 (so req 0 has top priority first), counter=0.
- While reset=1, req_ready=0.
- Period P = FRAME_CYCLES + GAP_CYCLES.
- States:
  - IDLE: no frame in flight.
  - SEND: tx_byte_ready=1 for exactly one cycle.
  - WAIT: counter counts down from P-1 to 1.
- Grant window: IDLE, or WAIT with counter==1.
  - In a grant window with any req_valid set, the winner is the first set bit searching upward from last_grant+1, with wrap-around modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle; the handshake completes on that edge.
- On handshake edge:
  - tx_data <= req_data[winner].
  - last_grant <= winner.
  - state -> SEND.
- SEND -> WAIT; counter <= P-1.
- WAIT: counter decrements each cycle. At counter==1, a handshake goes to SEND, otherwise to IDLE.
- Latency: handshake in cycle a -> tx_byte_ready high in cycle a+1.
- Back-to-back requests: tx_byte_ready pulses are exactly P cycles apart. Minimum spacing is never below P.
- tx_data holds its value until the next handshake. It is stable while tx_byte_ready=1.
- req_ready:
  - Never asserted outside a grant window or without the matching req_valid.
  - At most one bit is set at a time.
- Requesters must hold req_valid and req_data stable until the handshake. Dropping req_valid before ready is permitted; no byte is taken.
- Single requester valid: granted regardless of pointer position.
- Reset mid-frame: the arbiter returns to IDLE on that edge. The transmitter's own reset governs the line.
- busy=1 in SEND and WAIT, including the cycle in which a new grant occurs.

Decomposition:
- Package uart_pkg holds:
  - FRAME_CYCLES constant (10).
  - State encoding IDLE/SEND/WAIT (2 bits).
  - Counter width of 5 bits, covering P up to 25.
- Sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, grant index, any_grant.
  - Parameterised on NUM_REQ.
- Handshake, FSM and pacing counter stay in uart_tx_arbiter.

Test Plan:
- Reset high 3 cycles with req_valid=4'b1111 -> req_ready=0, tx_byte_ready=0, tx_data=00, busy=0, last_grant=3.
- Single req: req_valid=4'b0100, data2=8'hA5 in cycle a (IDLE) -> req_ready=4'b0100 in cycle a, tx_byte_ready=1 and tx_data=A5 in cycle a+1, busy=1 for cycles a+1..a+10, last_grant=2.
- All four valid continuously, distinct data 11/22/33/44 -> grants in order 0,1,2,3,0. tx_byte_ready pulses exactly 10 cycles apart (GAP_CYCLES=0). A connected transmitter's TXD reproduces frames 0|data LSB-first|1 with no truncation.
- Fairness: req0 and req3 always valid, last_grant=0 -> grants alternate 3,0,3,0. Neither requester is ever granted twice while the other waits.
- GAP_CYCLES=3, two requesters valid -> pulse spacing exactly 13 cycles. TXD=1 for 4 cycles between frames (stop bit plus 3 gap cycles).
- Reset asserted in WAIT with counter=5 -> next edge state=IDLE, busy=0. A pending req_valid is granted in the first cycle after reset deasserts, priority from index 0.
